// File: rtl/gray_fifo_ptr_ctrl_if.sv
// gray_fifo_ptr_ctrl_if: request/enable/pointer/status bundle between FIFO users and the pointer controller
interface gray_fifo_ptr_ctrl_if #(parameter int ADDR_WIDTH = 4);
  logic                  Flush_in;
  logic                  WrReq_in;
  logic                  RdReq_in;
  logic                  WrEn_out;
  logic                  RdEn_out;
  logic [ADDR_WIDTH-1:0] WrAddr_out;
  logic [ADDR_WIDTH-1:0] RdAddr_out;
  logic [ADDR_WIDTH:0]   WrPtrGray_out;
  logic [ADDR_WIDTH:0]   RdPtrGray_out;
  logic                  Full_out;
  logic                  Empty_out;
  logic [ADDR_WIDTH:0]   Level_out;
  logic                  Overflow_out;
  logic                  Underflow_out;
  modport master (
    output Flush_in, WrReq_in, RdReq_in,
    input  WrEn_out, RdEn_out, WrAddr_out, RdAddr_out, WrPtrGray_out, RdPtrGray_out,
    input  Full_out, Empty_out, Level_out, Overflow_out, Underflow_out
  );
  modport slave (
    input  Flush_in, WrReq_in, RdReq_in,
    output WrEn_out, RdEn_out, WrAddr_out, RdAddr_out, WrPtrGray_out, RdPtrGray_out,
    output Full_out, Empty_out, Level_out, Overflow_out, Underflow_out
  );
endinterface

// File: rtl/gray_fifo_ptr_ctrl.sv
// gray_fifo_ptr_ctrl: single-clock Gray pointer pair controller for a 2^ADDR_WIDTH-entry FIFO RAM
module gray_fifo_ptr_ctrl #(parameter int ADDR_WIDTH = 4) (
  input logic                 clk,
  input logic                 Reset_in,
  gray_fifo_ptr_ctrl_if.slave bus
);
  localparam int PW = ADDR_WIDTH + 1;
  localparam logic [PW-1:0] FULL_MASK = PW'(3) << (ADDR_WIDTH - 1);
  logic [PW-1:0] wr_bin, rd_bin, wr_bin_nx, rd_bin_nx;
  logic [PW-1:0] wr_gray, rd_gray, wr_gray_nx, rd_gray_nx;
  logic [PW-1:0] level;
  logic          full, empty, ovf, udf;
  logic          wr_en, rd_en;
  // Acceptance uses only registered flags so the enables never loop back through the pointers
  always_comb begin
    wr_en = bus.WrReq_in & ~full & ~bus.Flush_in & ~Reset_in;
    rd_en = bus.RdReq_in & ~empty & ~bus.Flush_in & ~Reset_in;
  end
  // Next-state pointers; flush folds in here so flags/level derive from the cleared pointers
  always_comb begin
    wr_bin_nx  = bus.Flush_in ? '0 : wr_bin + PW'(wr_en);
    rd_bin_nx  = bus.Flush_in ? '0 : rd_bin + PW'(rd_en);
    wr_gray_nx = wr_bin_nx ^ (wr_bin_nx >> 1);
    rd_gray_nx = rd_bin_nx ^ (rd_bin_nx >> 1);
  end
  // Pointer, Gray, flag and level registers; sticky errors survive flush but not reset
  always_ff @(posedge clk) begin
    if (Reset_in) begin
      wr_bin  <= '0;
      rd_bin  <= '0;
      wr_gray <= '0;
      rd_gray <= '0;
      level   <= '0;
      full    <= 1'b0;
      empty   <= 1'b1;
      ovf     <= 1'b0;
      udf     <= 1'b0;
    end else begin
      wr_bin  <= wr_bin_nx;
      rd_bin  <= rd_bin_nx;
      wr_gray <= wr_gray_nx;
      rd_gray <= rd_gray_nx;
      level   <= wr_bin_nx - rd_bin_nx;
      full    <= wr_gray_nx == (rd_gray_nx ^ FULL_MASK);
      empty   <= wr_gray_nx == rd_gray_nx;
      ovf     <= ovf | (bus.WrReq_in & full & ~bus.Flush_in);
      udf     <= udf | (bus.RdReq_in & empty & ~bus.Flush_in);
    end
  end
  // Drive the interface outputs
  always_comb begin
    bus.WrEn_out      = wr_en;
    bus.RdEn_out      = rd_en;
    bus.WrAddr_out    = wr_bin[ADDR_WIDTH-1:0];
    bus.RdAddr_out    = rd_bin[ADDR_WIDTH-1:0];
    bus.WrPtrGray_out = wr_gray;
    bus.RdPtrGray_out = rd_gray;
    bus.Full_out      = full;
    bus.Empty_out     = empty;
    bus.Level_out     = level;
    bus.Overflow_out  = ovf;
    bus.Underflow_out = udf;
  end
endmodule

// File: tb/tb_gray_fifo_ptr_ctrl.sv
// tb_gray_fifo_ptr_ctrl: directed and random checks of the pointer controller against an occupancy-count model
module tb_gray_fifo_ptr_ctrl;
  localparam int AW = 4;
  localparam int DEPTH = 1 << AW;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int tests = 0;
  int fails = 0;
  int w = 0;
  int r = 0;
  int lvl = 0;
  bit ovf = 0;
  bit udf = 0;
  logic [AW:0] pwg = '0;
  logic [AW:0] prg = '0;
  gray_fifo_ptr_ctrl_if #(.ADDR_WIDTH(AW)) bus ();
  gray_fifo_ptr_ctrl #(.ADDR_WIDTH(AW)) dut (.clk(clk), .Reset_in(rst), .bus(bus));
  always #5 clk = ~clk;
  function automatic logic [AW:0] gray(input int p);
    int b = p % (2 * DEPTH);
    return (AW + 1)'(b ^ (b >> 1));
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic step(input bit wr, input bit rd, input bit fl, input bit rs);
    bit we, re;
    @(negedge clk);
    bus.WrReq_in = wr;
    bus.RdReq_in = rd;
    bus.Flush_in = fl;
    rst = rs;
    #1;
    we = wr && !fl && !rs && lvl < DEPTH;
    re = rd && !fl && !rs && lvl > 0;
    chk("wr_en", 32'(bus.WrEn_out), 32'(we));
    chk("rd_en", 32'(bus.RdEn_out), 32'(re));
    @(posedge clk);
    if (rs) begin
      w = 0; r = 0; lvl = 0; ovf = 0; udf = 0;
    end else if (fl) begin
      w = 0; r = 0; lvl = 0;
    end else begin
      if (wr && lvl == DEPTH) ovf = 1;
      if (rd && lvl == 0) udf = 1;
      w = (w + int'(we)) % (2 * DEPTH);
      r = (r + int'(re)) % (2 * DEPTH);
      lvl = lvl + int'(we) - int'(re);
    end
    #1;
    chk("wr_addr", 32'(bus.WrAddr_out), 32'(w % DEPTH));
    chk("rd_addr", 32'(bus.RdAddr_out), 32'(r % DEPTH));
    chk("wr_gray", 32'(bus.WrPtrGray_out), 32'(gray(w)));
    chk("rd_gray", 32'(bus.RdPtrGray_out), 32'(gray(r)));
    chk("level", 32'(bus.Level_out), 32'(lvl));
    chk("full", 32'(bus.Full_out), 32'(lvl == DEPTH));
    chk("empty", 32'(bus.Empty_out), 32'(lvl == 0));
    chk("overflow", 32'(bus.Overflow_out), 32'(ovf));
    chk("underflow", 32'(bus.Underflow_out), 32'(udf));
    if (!rs && !fl && bus.WrPtrGray_out !== pwg)
      chk("wr_gray_onebit", 32'($countones(bus.WrPtrGray_out ^ pwg)), 32'd1);
    if (!rs && !fl && bus.RdPtrGray_out !== prg)
      chk("rd_gray_onebit", 32'($countones(bus.RdPtrGray_out ^ prg)), 32'd1);
    pwg = bus.WrPtrGray_out;
    prg = bus.RdPtrGray_out;
  endtask
  initial begin
    bus.WrReq_in = 1'b0;
    bus.RdReq_in = 1'b0;
    bus.Flush_in = 1'b0;
    step(1, 0, 0, 1);
    step(1, 1, 0, 1);
    chk("reset_gray_wr", 32'(bus.WrPtrGray_out), 32'd0);
    chk("reset_empty", 32'(bus.Empty_out), 32'd1);
    for (int i = 0; i < DEPTH; i++) step(1, 0, 0, 0);
    chk("fill_full", 32'(bus.Full_out), 32'd1);
    chk("fill_level", 32'(bus.Level_out), 32'd16);
    chk("fill_gray", 32'(bus.WrPtrGray_out), 32'b11000);
    step(1, 0, 0, 0);
    chk("fill_ovf", 32'(bus.Overflow_out), 32'd1);
    chk("fill_ptr_hold", 32'(bus.WrPtrGray_out), 32'b11000);
    for (int i = 0; i < DEPTH; i++) step(0, 1, 0, 0);
    chk("drain_empty", 32'(bus.Empty_out), 32'd1);
    chk("drain_gray", 32'(bus.RdPtrGray_out), 32'b11000);
    step(0, 1, 0, 0);
    chk("drain_udf", 32'(bus.Underflow_out), 32'd1);
    for (int i = 0; i < 5; i++) step(1, 0, 0, 0);
    for (int i = 0; i < 10; i++) step(1, 1, 0, 0);
    chk("simul_level", 32'(bus.Level_out), 32'd5);
    for (int i = 0; i < 11; i++) step(1, 0, 0, 0);
    step(1, 1, 0, 0);
    chk("simul_full_level", 32'(bus.Level_out), 32'd15);
    chk("simul_full_flag", 32'(bus.Full_out), 32'd0);
    step(0, 0, 0, 1);
    step(1, 1, 0, 0);
    chk("simul_empty_level", 32'(bus.Level_out), 32'd1);
    step(0, 0, 0, 1);
    for (int i = 0; i < 40; i++) begin
      step(1, 0, 0, 0);
      step(0, 1, 0, 0);
    end
    chk("wrap_wr_addr", 32'(bus.WrPtrGray_out), 32'(gray(40)));
    step(0, 0, 0, 1);
    for (int i = 0; i < 17; i++) step(1, 0, 0, 0);
    for (int i = 0; i < 9; i++) step(0, 1, 0, 0);
    chk("flush_pre_level", 32'(bus.Level_out), 32'd7);
    step(1, 0, 1, 0);
    chk("flush_level", 32'(bus.Level_out), 32'd0);
    chk("flush_empty", 32'(bus.Empty_out), 32'd1);
    chk("flush_ovf_kept", 32'(bus.Overflow_out), 32'd1);
    for (int i = 0; i < 2000; i++)
      step($urandom_range(0, 99) < 55, $urandom_range(0, 99) < 45,
           $urandom_range(0, 49) == 0, $urandom_range(0, 199) == 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/gray_fifo_ptr_ctrl.md
Name: gray_fifo_ptr_ctrl

Overview:
Single-clock FIFO pointer controller that sequences a write and a read Gray pointer pair around a 2^ADDR_WIDTH-entry RAM. It accepts write/read requests, generates RAM enables and binary addresses, and derives full, empty and level from the pointers. It exports registered Gray-coded pointers for downstream clock-domain-crossing logic. It sits between producer/consumer request logic and a simple dual-port RAM.

Parameters:
ADDR_WIDTH, 4, RAM address width; depth = 2^ADDR_WIDTH entries; pointers are ADDR_WIDTH+1 bits wide.

Ports:
clk  input  1  clock; all state updates on its rising edge
Reset_in  input  1  synchronous, active-high reset
Flush_in  input  1  synchronous pointer clear; sticky error flags are preserved
WrReq_in  input  1  producer write request
RdReq_in  input  1  consumer read request
WrEn_out  output  1  write accepted this cycle (RAM write enable)
RdEn_out  output  1  read accepted this cycle (RAM read enable)
WrAddr_out  output  ADDR_WIDTH  RAM write address, low bits of binary write pointer
RdAddr_out  output  ADDR_WIDTH  RAM read address, low bits of binary read pointer
WrPtrGray_out  output  ADDR_WIDTH+1  Gray-coded write pointer, registered
RdPtrGray_out  output  ADDR_WIDTH+1  Gray-coded read pointer, registered
Full_out  output  1  FIFO holds 2^ADDR_WIDTH entries, registered
Empty_out  output  1  FIFO holds 0 entries, registered
Level_out  output  ADDR_WIDTH+1  occupancy 0..2^ADDR_WIDTH, registered
Overflow_out  output  1  sticky: write requested while full
Underflow_out  output  1  sticky: read requested while empty

Behaviour:
- Reset (Reset_in=1): binary and Gray pointers = 0, Full_out=0, Empty_out=1, Level_out=0, Overflow_out=0, Underflow_out=0. WrEn_out and RdEn_out are forced to 0 during reset. Reset has priority over everything.
- Acceptance is combinational from registered flags:
  - WrEn_out = WrReq_in & ~Full_out & ~Flush_in & ~Reset_in
  - RdEn_out = RdReq_in & ~Empty_out & ~Flush_in & ~Reset_in
- Pointer update: on WrEn_out the binary write pointer increments by 1 mod 2^(ADDR_WIDTH+1). The read pointer does the same on RdEn_out.
- Gray outputs are registered together with the binary pointers, computed as next_bin ^ (next_bin >> 1). They therefore match the binary pointer in the same cycle, and exactly one Gray bit changes per increment, including at wrap.
- Flags and level are computed from the next-state pointers and registered, so they are valid the cycle after the accepting edge. No extra latency.
  - Empty when next wr Gray == next rd Gray.
  - Full when next wr Gray == next rd Gray with its top two bits inverted and the remaining bits equal.
  - Level = next wr bin - next rd bin, in ADDR_WIDTH+1 bits.
- Simultaneous read and write:
  - Both accepted: level unchanged, both pointers advance.
  - When full: only the read is accepted; the cycle after, Full_out=0 and Level = depth-1.
  - When empty: only the write is accepted; the cycle after, Empty_out=0 and Level=1.
- Overflow_out sets on any cycle with WrReq_in & Full_out; Underflow_out sets on RdReq_in & Empty_out. Both stay set until Reset_in; Flush_in does not clear them. A rejected request never moves a pointer.
- Flush_in=1 (without reset): pointers, Gray outputs, Level, Full and Empty take their reset values on the next edge. Requests in the flush cycle are ignored and do not set the sticky flags.
- Wrap-around: pointers run through 2·depth states. After 2·depth accepted writes, the write pointer returns to 0.

Test Plan:
- Reset check: assert Reset_in with WrReq_in=1 -> WrEn_out=0; after release, Empty_out=1, Full_out=0, Level_out=0, both Gray pointers 5'b00000.
- Fill (ADDR_WIDTH=4): 16 consecutive writes -> Full_out=1 the cycle after the 16th, Level_out=16, WrPtrGray_out=5'b11000. A 17th request gives WrEn_out=0, Overflow_out=1, and the pointer is unchanged.
- Drain: 16 reads from full -> Empty_out=1, Level_out=0, RdPtrGray_out=5'b11000. A further read gives RdEn_out=0 and Underflow_out=1.
- Simultaneous operation: hold Level=5, assert WrReq_in and RdReq_in for 10 cycles -> Level_out stays 5 and both pointers advance by 10. Repeat at full -> read only accepted, Level 15.
- Wrap and Gray property: 40 write/read pairs -> both pointers pass through 0 after 32 increments; every Gray pointer change differs by exactly one bit.
- Flush mid-operation: Level=7 with Overflow_out=1, pulse Flush_in with WrReq_in=1 -> next cycle Level=0, Empty=1, pointers 0, no write accepted, Overflow_out still 1.
